lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator that drives the word-wide, single-port data RAM on behalf of the core. Accepts byte/half/word load and store requests over a valid/ready handshake, issues word reads and writes to the RAM, and sign- or zero-extends load data. Because the RAM has no byte enables, sub-word stores are done as read-modify-write. Sits between the core's memory stage and the RAM.

## Interface
- ADDR_W, 10, RAM word-address width; byte address is ADDR_W+2 bits
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts request; transfer on req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W+2  byte address, little-endian
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected, no memory access made
- mem_we  out  1  RAM write strobe
- mem_addr  out  ADDR_W  RAM word address = req_addr[ADDR_W+1:2]
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM registered read data, valid the cycle after the read address is sampled

## Operation
- FSM states: IDLE, RD, RD_WAIT, WR, RESP.
- IDLE: req_ready=1. On handshake, register the request, then:
  - error → RESP
  - load or sub-word store → RD
  - word store → WR
- RD: mem_we=0 and mem_addr driven. Next state is RD_WAIT.
- RD_WAIT: capture mem_rdata.
  - Load: extract the lane, extend it, go to RESP.
  - Sub-word store: merge into the captured word, go to WR.
- WR: mem_we=1 with merged or full data for exactly one cycle, then RESP.
- RESP: rsp_valid=1. On rsp_ready, go to IDLE. req_ready=0 in every state except IDLE.
- Byte lane: addr[1:0]. Half lane: addr[1]. Byte store replaces bits [8*k+7:8*k] with wdata[7:0]. Half store replaces bits [16*h+15:16*h] with wdata[15:0].
- Sign extension uses bit 7 for bytes and bit 15 for halves.
- req_size=11 always produces an error response.
- mem_we=0 in every state except WR. mem_addr and mem_wdata hold their last values when idle.

## Timing
- Request accepted at edge T. Then:
  - Word store: write in cycle T+1, rsp_valid from T+2.
  - Load: rsp_valid from T+3.
  - Sub-word store: write in cycle T+3, rsp_valid from T+4.
  - Error: rsp_valid from T+1.
- Back-to-back requests: next accept no earlier than the cycle after the response handshake.
- Reset values: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, req_ready=0 while rst_n=0.
- Reset mid-operation: the operation is abandoned and mem_we is low from the next cycle. A pending RMW write never occurs. A pending response is dropped.
- rsp_rdata and rsp_err are stable while rsp_valid=1 and rsp_ready=0.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0, is an error: no memory access, rsp_err=1, rsp_rdata=0.
- MISALIGN_TRAP_EN undefined:
  - Offending low address bits are ignored. Half uses addr[1] only; word uses addr[1:0]=00.
  - rsp_err is asserted only for req_size=11.

## Structure
- Package lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, and the lane-extract / extend function.
- Sub-module lsu_lane_merge: combinational merge of (old word, wdata, size, addr[1:0]) into the new word. Instantiated once.

## Test plan
- Word store 0xDEADBEEF to 0x010, then word load from 0x010 → mem_we one cycle at T+1 with mem_addr=4; load rsp_rdata=0xDEADBEEF at T+3, rsp_err=0.
- Signed byte load from 0x013 when the word holds 0x80FF7F01 → rsp_rdata=0xFFFFFF80. Same access with req_unsigned=1 → 0x00000080.
- Half store 0xABCD to 0x012 over word 0x11223344 → one read, then one write of 0xABCD3344. rsp_valid at T+4.
- Word load at 0x006 → with MISALIGN_TRAP_EN: rsp_err=1 at T+1 and no mem_we or read issued. Without it: reads word address 1, rsp_err=0.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and data stable, req_ready=0. Drop rsp_ready low again after the handshake → next request is accepted only in IDLE.
- Assert rst_n=0 during RD_WAIT of a byte store → no write ever occurs, all outputs at reset values the next cycle. req_ready=1 the first cycle after rst_n=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: access-size encodings,
// FSM state type and the load-lane extract/extend helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    RESP
  } lsu_state_t;

  // Picks the addressed lane out of a RAM word and sign- or zero-extends it.
  function automatic logic [31:0] lane_extend(input logic [31:0] w,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo,
                                              input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: lane_extend = {{24{~is_unsigned & b[7]}}, b};
      SZ_HALF: lane_extend = {{16{~is_unsigned & h[15]}}, h};
      default: lane_extend = w;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational read-modify-write merge: drops store data into the addressed
// byte or half lane of the word read back from the RAM.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    case (size)
      SZ_BYTE: new_word[{lo, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: new_word[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: new_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-wide single-port data RAM; sub-word stores
// are read-modify-write. Define MISALIGN_TRAP_EN to reject misaligned half/word.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t  state;
  logic        r_we;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [1:0]  r_lo;
  logic [31:0] r_wdata;
  logic [31:0] merged;
  logic        req_err;

  always_comb begin
    req_err = (req_size == SZ_RSVD);
`ifdef MISALIGN_TRAP_EN
    if (req_size == SZ_HALF && req_addr[0])          req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  lsu_lane_merge u_lane_merge (
    .old_word (mem_rdata),
    .wdata    (r_wdata),
    .size     (r_size),
    .lo       (r_lo),
    .new_word (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_BYTE;
      r_lo       <= 2'b00;
      r_wdata    <= '0;
    end else begin
      // NOTE: non-blocking default; only the WR entry below overrides it, so
      // mem_we is a one-cycle pulse with no chance of a stale strobe.
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_lo       <= req_addr[1:0];
            r_wdata    <= req_wdata;
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else begin
              mem_addr <= req_addr[ADDR_W+1:2];
              if (req_we && req_size == SZ_WORD) begin
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
                state     <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: begin
          // Registered RAM data is valid here, one cycle after the address.
          if (r_we) begin
            mem_we    <= 1'b1;
            mem_wdata <= merged;
            state     <= WR;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= lane_extend(mem_rdata, r_size, r_lo, r_unsigned);
            state     <= RESP;
          end
        end
        WR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, hand-written
// hold/back-to-back/reset sequences, then random traffic against a byte model.
module tb_lsu_mem_master;

  localparam int ADDR_W = 10;
  localparam int NWORDS = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // RAM with registered read; preload port lets the bench seed contents.
  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0]       pl_data = '0;
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [31:0]       last_wr_data = '0;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_wr_addr  <= mem_addr;
      last_wr_data  <= mem_wdata;
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: byte-addressed little-endian memory.
  logic [7:0] mmem [0:4*NWORDS-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic preload(input int wa, input logic [31:0] val);
    pl_en   = 1'b1;
    pl_addr = ADDR_W'(wa);
    pl_data = val;
    for (int i = 0; i < 4; i++) mmem[4*wa+i] = val[8*i +: 8];
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Computes the expected result from the access rules and updates the model.
  task automatic model_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [11:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int wr);
    int     n;
    int     base;
    longint v;
    er = (size == 2'd3);
`ifdef MISALIGN_TRAP_EN
    if (size == 2'd1 && addr[0]) er = 1'b1;
    if (size == 2'd2 && addr[1:0] != 2'b00) er = 1'b1;
`endif
    rd = '0;
    wr = 0;
    lat = 1;
    if (!er) begin
      n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      base = (int'(addr) / n) * n;
      if (we) begin
        for (int i = 0; i < n; i++) mmem[base+i] = wdata[8*i +: 8];
        lat = (n == 4) ? 2 : 4;
        wr  = 1;
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mmem[base+i]) << (8*i);
        if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
        rd  = v[31:0];
        lat = 3;
      end
    end
  endtask

  // Runs one request/response; latency counts cycles from accept to rsp_valid.
  task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int nwr);
    int          wc0;
    int          guard;
    logic        busy_ok;
    logic [31:0] r0;
    logic        e0;
    busy_ok      = 1'b1;
    rdata        = '0;
    err          = 1'b0;
    nwr          = 0;
    lat          = 99;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    wc0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (req_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    nwr   = wr_cnt - wc0;
    if (rsp_valid) begin
      r0 = rsp_rdata;
      e0 = rsp_err;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!rsp_valid || rsp_rdata !== r0 || rsp_err !== e0 || req_ready || mem_we)
          busy_ok = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    check("busy_outputs_ok", 32'(busy_ok), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic        do_pl;
    int          pl_wa;
    logic [31:0] pl_data;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_wr_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic do_pl, input int pl_wa,
                              input logic [31:0] pl_data, input logic we, input logic [1:0] size,
                              input logic uns, input logic [11:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_wr, input logic [31:0] exp_wr_data);
    vec_t v;
    v.name = name; v.do_pl = do_pl; v.pl_wa = pl_wa; v.pl_data = pl_data;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_wr = exp_wr; v.exp_wr_data = exp_wr_data;
    return v;
  endfunction

  initial begin : main
    logic [31:0]       rd;
    logic              er;
    int                lat;
    int                nwr;
    logic [31:0]       m_rd;
    logic              m_er;
    int                m_lat;
    int                m_wr;
    logic [ADDR_W-1:0] addr0;
    logic              ok;
    int                guard;
    int                wc0;
    int                bad;
    logic [31:0]       snap;

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_we = 1'b0;
    req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    check("rst_mem_we",    32'(mem_we), 32'd0);
    check("rst_mem_addr",  32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    for (int w = 0; w < NWORDS; w++) preload(w, $urandom);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed vectors
    vecs.push_back(mk("st_word",  0, 0, 0,            1, 2'd2, 0, 12'h010, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF));
    vecs.push_back(mk("ld_word",  0, 0, 0,            0, 2'd2, 0, 12'h010, 32'h0,        32'hDEADBEEF, 0, 3, 0, 32'h0));
    vecs.push_back(mk("ld_b3_s",  1, 4, 32'h80FF7F01, 0, 2'd0, 0, 12'h013, 32'h0,        32'hFFFFFF80, 0, 3, 0, 32'h0));
    vecs.push_back(mk("ld_b3_u",  0, 0, 0,            0, 2'd0, 1, 12'h013, 32'h0,        32'h00000080, 0, 3, 0, 32'h0));
    vecs.push_back(mk("ld_b2_s",  0, 0, 0,            0, 2'd0, 0, 12'h012, 32'h0,        32'hFFFFFFFF, 0, 3, 0, 32'h0));
    vecs.push_back(mk("ld_b1_s",  0, 0, 0,            0, 2'd0, 0, 12'h011, 32'h0,        32'h0000007F, 0, 3, 0, 32'h0));
    vecs.push_back(mk("ld_h0_s",  0, 0, 0,            0, 2'd1, 0, 12'h010, 32'h0,        32'h00007F01, 0, 3, 0, 32'h0));
    vecs.push_back(mk("ld_h1_s",  0, 0, 0,            0, 2'd1, 0, 12'h012, 32'h0,        32'hFFFF80FF, 0, 3, 0, 32'h0));
    vecs.push_back(mk("ld_h1_u",  0, 0, 0,            0, 2'd1, 1, 12'h012, 32'h0,        32'h000080FF, 0, 3, 0, 32'h0));
    vecs.push_back(mk("st_half",  1, 4, 32'h11223344, 1, 2'd1, 0, 12'h012, 32'h1234ABCD, 32'h0,        0, 4, 1, 32'hABCD3344));
    vecs.push_back(mk("ld_aft_h", 0, 0, 0,            0, 2'd2, 0, 12'h010, 32'h0,        32'hABCD3344, 0, 3, 0, 32'h0));
    vecs.push_back(mk("st_byte",  0, 0, 0,            1, 2'd0, 0, 12'h011, 32'hFFFFFF5A, 32'h0,        0, 4, 1, 32'hABCD5A44));
    vecs.push_back(mk("ld_aft_b", 0, 0, 0,            0, 2'd2, 0, 12'h010, 32'h0,        32'hABCD5A44, 0, 3, 0, 32'h0));
    vecs.push_back(mk("rsvd_ld",  0, 0, 0,            0, 2'd3, 0, 12'h010, 32'h0,        32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk("rsvd_st",  0, 0, 0,            1, 2'd3, 0, 12'h010, 32'h55555555, 32'h0,        1, 1, 0, 32'h0));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk("ld_w_mis", 1, 1, 32'hCAFEF00D, 0, 2'd2, 0, 12'h006, 32'h0,        32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk("st_h_mis", 0, 0, 0,            1, 2'd1, 0, 12'h005, 32'h00009999, 32'h0,        1, 1, 0, 32'h0));
`else
    vecs.push_back(mk("ld_w_mis", 1, 1, 32'hCAFEF00D, 0, 2'd2, 0, 12'h006, 32'h0,        32'hCAFEF00D, 0, 3, 0, 32'h0));
    vecs.push_back(mk("st_h_mis", 0, 0, 0,            1, 2'd1, 0, 12'h005, 32'h00009999, 32'h0,        0, 4, 1, 32'hCAFE9999));
`endif

    foreach (vecs[i]) begin
      if (vecs[i].do_pl) preload(vecs[i].pl_wa, vecs[i].pl_data);
      model_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                m_rd, m_er, m_lat, m_wr);
      addr0 = mem_addr;
      do_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 0,
             rd, er, lat, nwr);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, "_writes"}, 32'(nwr), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr == 1) begin
        check({vecs[i].name, "_wr_data"}, last_wr_data, vecs[i].exp_wr_data);
        check({vecs[i].name, "_wr_addr"}, 32'(last_wr_addr), 32'(vecs[i].addr[11:2]));
      end
      if (vecs[i].exp_err) check({vecs[i].name, "_no_access"}, 32'(mem_addr), 32'(addr0));
      else                 check({vecs[i].name, "_mem_addr"}, 32'(mem_addr), 32'(vecs[i].addr[11:2]));
    end

    // Response held for 5 cycles while a word store is already waiting.
    preload(8, 32'h13579BDF);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 12'h020; req_wdata = '0;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 12'h024; req_wdata = 32'h2468ACE0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    check("hold_first_rdata", rsp_rdata, 32'h13579BDF);
    snap = rsp_rdata;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== snap || rsp_err || req_ready || mem_we) ok = 1'b0;
    end
    check("hold_stable", 32'(ok), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("b2b_idle_ready", 32'(req_ready), 32'd1);
    check("b2b_no_early_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_store_we", 32'(mem_we), 32'd1);
    check("b2b_store_addr", 32'(mem_addr), 32'd9);
    for (int i = 0; i < 4; i++) mmem[36+i] = req_wdata[8*i +: 8];
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset during RD_WAIT of a byte store: the RMW write must never happen.
    preload(10, 32'h01020304);
    wc0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 12'h029; req_wdata = 32'h000000EE;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    check("mid_rst_rsp_err",   32'(rsp_err), 32'd0);
    check("mid_rst_mem_we",    32'(mem_we), 32'd0);
    check("mid_rst_mem_addr",  32'(mem_addr), 32'd0);
    check("mid_rst_mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready_after", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_write", 32'(wr_cnt - wc0), 32'd0);
    model_txn(1'b0, 2'd2, 1'b0, 12'h028, 32'h0, m_rd, m_er, m_lat, m_wr);
    do_txn(1'b0, 2'd2, 1'b0, 12'h028, 32'h0, 0, rd, er, lat, nwr);
    check("mid_rst_word_kept", rd, m_rd);

    // Random traffic against the model
    for (int t = 0; t < 300; t++) begin
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [11:0] addr;
      logic [31:0] wdata;
      int          r;
      r     = $urandom_range(0, 7);
      size  = (r < 7) ? 2'(r % 3) : 2'd3;
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      addr  = 12'($urandom_range(0, 4*NWORDS-1));
      wdata = $urandom;
      addr0 = mem_addr;
      model_txn(we, size, uns, addr, wdata, m_rd, m_er, m_lat, m_wr);
      do_txn(we, size, uns, addr, wdata, $urandom_range(0, 2), rd, er, lat, nwr);
      check($sformatf("rnd%0d_rdata", t), rd, m_rd);
      check($sformatf("rnd%0d_err", t), 32'(er), 32'(m_er));
      check($sformatf("rnd%0d_lat", t), 32'(lat), 32'(m_lat));
      check($sformatf("rnd%0d_writes", t), 32'(nwr), 32'(m_wr));
      if (m_er) check($sformatf("rnd%0d_no_access", t), 32'(mem_addr), 32'(addr0));
      else      check($sformatf("rnd%0d_mem_addr", t), 32'(mem_addr), 32'(addr[11:2]));
    end

    bad = 0;
    for (int w = 0; w < NWORDS; w++)
      if (ram[w] !== {mmem[4*w+3], mmem[4*w+2], mmem[4*w+1], mmem[4*w]}) bad++;
    check("final_ram_contents", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
